// File: rtl/io_map_pkg.sv
// Shared definitions for the CPU data-port I/O window: register map,
// STATUS bit layout and the UART serializer state encoding.
package io_map_pkg;

   localparam logic [1:0]  IO_WINDOW_SEL = 2'b11;

   localparam logic [13:0] ADDR_LED    = 14'h3000;
   localparam logic [13:0] ADDR_TX     = 14'h3001;
   localparam logic [13:0] ADDR_STATUS = 14'h3002;
   localparam logic [13:0] ADDR_CYCLE  = 14'h3003;
   localparam logic [13:0] ADDR_DROPS  = 14'h3004;

   localparam int ST_FULL_BIT  = 0;
   localparam int ST_EMPTY_BIT = 1;
   localparam int ST_BUSY_BIT  = 2;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_START,
      SER_DATA,
      SER_STOP
   } ser_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter. Pulls bytes with a valid/ready handshake and chains
// frames with no idle gap while bytes keep arriving.
module uart_tx_serializer
   import io_map_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_txd,
   output logic       o_busy
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   ser_state_t    r_state, w_state_nxt;
   logic [BW-1:0] r_baud, w_baud_nxt;
   logic [2:0]    r_bit, w_bit_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic          r_txd, w_txd_nxt;
   logic          w_baud_done;

   assign w_baud_done = (r_baud == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SER_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_txd   <= w_txd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_shift <= w_shift_nxt;
   end

   // txd is computed for the state being entered so the output stays registered
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = w_baud_done ? '0 : r_baud + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_txd_nxt   = r_txd;
      o_ready     = 1'b0;
      case (r_state)
         SER_IDLE: begin
            w_baud_nxt = '0;
            w_txd_nxt  = 1'b1;
            if (i_valid) begin
               o_ready     = 1'b1;
               w_shift_nxt = i_data;
               w_state_nxt = SER_START;
               w_txd_nxt   = 1'b0;
            end
         end
         SER_START: begin
            if (w_baud_done) begin
               w_state_nxt = SER_DATA;
               w_bit_nxt   = '0;
               w_txd_nxt   = r_shift[0];
            end
         end
         SER_DATA: begin
            if (w_baud_done) begin
               if (r_bit == 3'd7) begin
                  w_state_nxt = SER_STOP;
                  w_txd_nxt   = 1'b1;
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_txd_nxt   = r_shift[1];
               end
            end
         end
         SER_STOP: begin
            if (w_baud_done) begin
               if (i_valid) begin
                  o_ready     = 1'b1;
                  w_shift_nxt = i_data;
                  w_state_nxt = SER_START;
                  w_txd_nxt   = 1'b0;
               end else begin
                  w_state_nxt = SER_IDLE;
                  w_txd_nxt   = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = SER_IDLE;
            w_txd_nxt   = 1'b1;
         end
      endcase
   end

   assign o_txd  = r_txd;
   assign o_busy = (r_state != SER_IDLE);

endmodule

// File: rtl/data_io_responder.sv
// Target side of the CPU data port for the I/O window: LED, cycle and drop
// counters, and a TX FIFO feeding the UART serializer.
module data_io_responder
   import io_map_pkg::*;
#(
   parameter int CLKS_PER_BIT    = 434,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] dataAddress,
   input  logic        dataWrEn,
   input  logic [31:0] dataFromCpu,
   output logic [31:0] dataToCpu,
   output logic        ioSel,
   output logic [7:0]  leds,
   output logic        txd,
   output logic        txIrq
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;

   logic [7:0]                 r_mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]              r_count;
   logic [7:0]                 r_leds;
   logic [31:0]                r_cycle;
   logic [15:0]                r_drops;

   logic        w_full, w_empty, w_wr_io, w_push_req, w_push, w_drop, w_pop;
   logic        w_ser_ready, w_busy, w_unused;
   logic [31:0] w_status, w_rdata;

   assign ioSel      = (dataAddress[13:12] == IO_WINDOW_SEL);
   assign w_wr_io    = dataWrEn && ioSel;
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_push_req = w_wr_io && (dataAddress == ADDR_TX);
   assign w_push     = w_push_req && !w_full;
   assign w_drop     = w_push_req && w_full;
   assign w_pop      = w_ser_ready && !w_empty;
   assign w_unused   = ^dataFromCpu[31:8];

   // Full/empty come from pre-edge state, so a push on a full FIFO drops even if a pop lands
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= dataFromCpu[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_leds  <= '0;
         r_cycle <= '0;
         r_drops <= '0;
      end else begin
         if (w_wr_io && (dataAddress == ADDR_LED)) r_leds <= dataFromCpu[7:0];
         if (w_wr_io && (dataAddress == ADDR_CYCLE)) r_cycle <= '0;
         else                                        r_cycle <= r_cycle + 32'd1;
         if (w_wr_io && (dataAddress == ADDR_DROPS))  r_drops <= '0;
         else if (w_drop && (r_drops != 16'hFFFF))    r_drops <= r_drops + 16'd1;
      end
   end

   uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk     (clk),
      .rst     (rst),
      .i_data  (r_mem[r_rd_ptr]),
      .i_valid (!w_empty),
      .o_ready (w_ser_ready),
      .o_txd   (txd),
      .o_busy  (w_busy)
   );

   always_comb begin
      w_status                      = '0;
      w_status[ST_FULL_BIT]         = w_full;
      w_status[ST_EMPTY_BIT]        = w_empty;
      w_status[ST_BUSY_BIT]         = w_busy;
      w_status[ST_COUNT_LSB +: CW]  = r_count;
      w_rdata                       = '0;
      case (dataAddress)
         ADDR_LED:    w_rdata = {24'd0, r_leds};
         ADDR_STATUS: w_rdata = w_status;
         ADDR_CYCLE:  w_rdata = r_cycle;
         ADDR_DROPS:  w_rdata = {16'd0, r_drops};
         default:     w_rdata = '0;
      endcase
   end

   assign dataToCpu = ioSel ? w_rdata : 32'd0;
   assign leds      = r_leds;
   assign txIrq     = w_empty && !w_busy;

endmodule

// File: tb/tb_data_io_responder.sv
// Bench for data_io_responder: directed bus traffic with a UART frame
// scoreboard that decodes txd independently of the stimulus.
module tb_data_io_responder;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] dataAddress;
   logic        dataWrEn;
   logic [31:0] dataFromCpu;
   logic [31:0] dataToCpu;
   logic        ioSel;
   logic [7:0]  leds;
   logic        txd;
   logic        txIrq;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [7:0] exp_q[$];
   int         starts_q[$];

   data_io_responder #(
      .CLKS_PER_BIT    (CPB),
      .FIFO_DEPTH_LOG2 (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dataAddress (dataAddress),
      .dataWrEn    (dataWrEn),
      .dataFromCpu (dataFromCpu),
      .dataToCpu   (dataToCpu),
      .ioSel       (ioSel),
      .leds        (leds),
      .txd         (txd),
      .txIrq       (txIrq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [13:0] a, input logic [31:0] d);
      @(negedge clk);
      dataAddress = a;
      dataFromCpu = d;
      dataWrEn    = 1'b1;
      @(negedge clk);
      dataWrEn    = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
      dataAddress = a;
      #1;
      chk(name, dataToCpu, exp);
   endtask

   // Frame monitor: each frame found on txd is decoded and compared with the queue head
   initial begin
      logic [7:0] b;
      logic [7:0] got;
      logic [9:0] frame;
      logic       ok;
      logic       aborted;
      logic       have_exp;
      int         st;
      forever begin
         @(negedge clk);
         #2;
         if (rst !== 1'b0 || txd !== 1'b0) continue;
         st = cyc;
         have_exp = (exp_q.size() != 0);
         b = have_exp ? exp_q.pop_front() : 8'h00;
         frame = {1'b1, b, 1'b0};
         ok = 1'b1;
         aborted = 1'b0;
         got = 8'h00;
         for (int k = 0; k < 10 * CPB; k++) begin
            if (k != 0) begin
               @(negedge clk);
               #2;
            end
            if (rst) begin
               aborted = 1'b1;
               break;
            end
            if (txd !== frame[k / CPB]) ok = 1'b0;
            if ((k % CPB) == (CPB / 2) && (k / CPB) >= 1 && (k / CPB) <= 8)
               got[(k / CPB) - 1] = txd;
         end
         if (!aborted) begin
            starts_q.push_back(st);
            if (have_exp) chk("uart_frame", {23'd0, ok, got}, {23'd0, 1'b1, b});
            else          chk("unexpected_frame", {24'd0, got}, 32'hFFFF_FFFF);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      int bad;
      int low_cnt;
      int t;
      rst = 1'b1;
      dataAddress = 14'd0;
      dataWrEn = 1'b0;
      dataFromCpu = 32'd0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("reset_status", 14'h3002, 32'h0000_0002);
      chk("reset_leds", 32'(leds), 32'h0);
      chk("reset_txd", 32'(txd), 32'h1);
      chk("reset_txirq", 32'(txIrq), 32'h1);
      rd_chk("reset_drops", 14'h3004, 32'h0);

      // LED register and window decode
      wr(14'h3000, 32'hFFFF_FFA5);
      chk("led_value", 32'(leds), 32'hA5);
      rd_chk("led_read", 14'h3000, 32'h0000_00A5);
      chk("iosel_in_window", 32'(ioSel), 32'h1);
      wr(14'h0100, 32'h0000_005A);
      chk("led_outside_write", 32'(leds), 32'hA5);
      dataAddress = 14'h0100;
      #1;
      chk("iosel_outside", 32'(ioSel), 32'h0);
      chk("read_outside", dataToCpu, 32'h0);
      rd_chk("tx_reads_zero", 14'h3001, 32'h0);
      rd_chk("unmapped_reads_zero", 14'h3005, 32'h0);
      wr(14'h3002, 32'hFFFF_FFFF);
      rd_chk("status_write_ignored", 14'h3002, 32'h0000_0002);

      // Single frame
      exp_q.push_back(8'h55);
      wr(14'h3001, 32'h0000_0055);
      rd_chk("status_one_queued", 14'h3002, 32'h0000_0100);
      busy_cnt = 0;
      for (int i = 0; i < 10 * CPB; i++) begin
         @(negedge clk);
         #1;
         if (dataToCpu[2]) busy_cnt++;
      end
      chk("busy_whole_frame", 32'(busy_cnt), 32'(10 * CPB));
      @(negedge clk);
      #1;
      chk("txirq_after_frame", 32'(txIrq), 32'h1);
      chk("txd_after_frame", 32'(txd), 32'h1);
      chk("status_after_frame", dataToCpu, 32'h0000_0002);
      chk("frame1_seen", 32'(exp_q.size()), 32'h0);

      // Fill to full, drop the 18th push
      starts_q.delete();
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         dataAddress = 14'h3001;
         dataFromCpu = 32'(8'h10 + i);
         dataWrEn = 1'b1;
         if (i < 17) exp_q.push_back(8'(8'h10 + i));
      end
      @(negedge clk);
      dataWrEn = 1'b0;
      rd_chk("status_full", 14'h3002, 32'h0000_1005);
      rd_chk("drops_one", 14'h3004, 32'h0000_0001);
      chk("txirq_busy", 32'(txIrq), 32'h0);
      t = 0;
      while (t < 17 * 10 * CPB + 100 && !(exp_q.size() == 0 && txIrq === 1'b1)) begin
         @(negedge clk);
         t++;
      end
      #1;
      chk("drain_in_time", 32'(txIrq), 32'h1);
      chk("frames_count", 32'(starts_q.size()), 32'd17);
      bad = 0;
      for (int i = 1; i < starts_q.size(); i++)
         if (starts_q[i] - starts_q[i-1] != 10 * CPB) bad++;
      chk("no_interframe_gap", 32'(bad), 32'h0);
      rd_chk("drops_kept", 14'h3004, 32'h0000_0001);
      wr(14'h3004, 32'h1234_5678);
      rd_chk("drops_cleared", 14'h3004, 32'h0);
      rd_chk("status_drained", 14'h3002, 32'h0000_0002);

      // Cycle counter clear and wrap
      wr(14'h3003, 32'hDEAD_BEEF);
      rd_chk("cycle_0", 14'h3003, 32'd0);
      @(negedge clk);
      rd_chk("cycle_1", 14'h3003, 32'd1);
      @(negedge clk);
      rd_chk("cycle_2", 14'h3003, 32'd2);
      @(negedge clk);
      force dut.r_cycle = 32'hFFFF_FFFF;
      rd_chk("cycle_forced", 14'h3003, 32'hFFFF_FFFF);
      release dut.r_cycle;
      @(negedge clk);
      rd_chk("cycle_wrap", 14'h3003, 32'd0);

      // Reset during data bit 3 with bytes queued
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         dataAddress = 14'h3001;
         dataFromCpu = 32'(8'hA1 + i);
         dataWrEn = 1'b1;
         exp_q.push_back(8'(8'hA1 + i));
      end
      @(negedge clk);
      dataWrEn = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rd_chk("midframe_reset_status", 14'h3002, 32'h0000_0002);
      chk("midframe_reset_txd", 32'(txd), 32'h1);
      chk("midframe_reset_txirq", 32'(txIrq), 32'h1);
      rst = 1'b0;
      exp_q.delete();
      low_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (txd !== 1'b1) low_cnt++;
      end
      chk("no_frames_after_reset", 32'(low_cnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
